// File: rtl/instr_decoder_pkg.sv
// Shared constants for the pipelined instruction decoder: data-bus source codes,
// opcode prefixes, register indices and the jump-tracker state type.
package instr_decoder_pkg;

  localparam logic [3:0] SRC_REG0 = 4'd0, SRC_REG1 = 4'd1, SRC_REG2 = 4'd2, SRC_REG3 = 4'd3;
  localparam logic [3:0] SRC_REG4 = 4'd4, SRC_REG5 = 4'd5, SRC_REG6 = 4'd6, SRC_REG7 = 4'd7;
  localparam logic [3:0] IMM_SRC  = 4'd8;
  localparam logic [3:0] IPIN_SRC = 4'd9;
  localparam logic [3:0] ZERO_SRC = 4'd10;
  localparam logic [3:0] R_SRC    = 4'd4;

  // Opcode prefixes, matched against the top bits of ir.
  localparam logic       OP_LOAD = 1'b0;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [2:0] OP_ALU  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  localparam logic [3:0] REG_R  = 4'd4;
  localparam logic [3:0] REG_I  = 4'd6;
  localparam logic [3:0] REG_DM = 4'd7;
  localparam logic [3:0] REG_O  = 4'd8;

  typedef enum logic [0:0] {StExec, StJaddr} jmp_state_e;

  // Destination field 4 addresses the output register, which lives at enable 8.
  function automatic logic [3:0] dst_index(input logic [2:0] dst);
    return ({1'b0, dst} == REG_R) ? REG_O : {1'b0, dst};
  endfunction

endpackage

// File: rtl/jmp_tracker.sv
// Tracks the address words that follow a jump opcode in the decode stage and
// flags the final one together with the latched jump condition.
module jmp_tracker
  import instr_decoder_pkg::*;
#(
  parameter int unsigned JMP_ADDR_WORDS = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic ir_v_i,
  input  logic stall_i,
  input  logic is_jmp_i,
  input  logic cond_i,
  output logic busy_o,
  output logic last_word_o,
  output logic cond_o
);

  localparam int unsigned CntW = (JMP_ADDR_WORDS > 1) ? $clog2(JMP_ADDR_WORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(JMP_ADDR_WORDS - 1);

  jmp_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cond_q, cond_d;
  logic            advance;

  // The decode stage consumes the word in ir only when it is valid and not stalled.
  assign advance = ir_v_i & ~stall_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StExec;
      cnt_q   <= '0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cond_d      = cond_q;
    busy_o      = (state_q == StJaddr) || (ir_v_i && is_jmp_i);
    last_word_o = (state_q == StJaddr) && ir_v_i && (cnt_q == '0);
    cond_o      = cond_q;
    if (advance) begin
      unique case (state_q)
        StExec: begin
          if (is_jmp_i) begin
            state_d = StJaddr;
            cnt_d   = LastCnt;
            cond_d  = cond_i;
          end
        end
        StJaddr: begin
          if (cnt_q == '0) state_d = StExec;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        default: state_d = StExec;
      endcase
    end
  end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Registered, handshaked instruction decoder with multi-word jump tracking.
// Define INSTR_DECODER_TRACE_EN to add dbg_ir_o / dbg_retired_o and a reg_en check.
module instr_decoder_pipe
  import instr_decoder_pkg::*;
#(
  parameter  int unsigned NIBBLE_W       = 4,
  parameter  int unsigned JMP_ADDR_WORDS = 1,
  parameter  int unsigned NUM_DST        = 9,
  localparam int unsigned W              = 2 * NIBBLE_W
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [W-1:0]        next_instr_i,
  input  logic                instr_valid_i,
  input  logic                stall_i,
  output logic                instr_ready_o,
  output logic [NIBBLE_W-1:0] ir_nibble_o,
  output logic [3:0]          source_sel_o,
  output logic [NUM_DST-1:0]  reg_en_o,
  output logic                i_sel_o,
  output logic                x_sel_o,
  output logic                y_sel_o,
  output logic [2:0]          alu_func_o,
  output logic                jmp_o,
  output logic                jmp_nz_o,
  output logic                jmp_busy_o
`ifdef INSTR_DECODER_TRACE_EN
  ,
  output logic [W-1:0]        dbg_ir_o,
  output logic [15:0]         dbg_retired_o
`endif
);

  localparam logic [NUM_DST-1:0] EnOne = NUM_DST'(1);

  logic [W-1:0] ir_q, ir_d;
  logic         ir_v_q, ir_v_d;
  logic         busy, last_word, cond, bubble;
  logic [2:0]   ld_dst, dst, src;

  always_comb begin
    ir_d   = ir_q;
    ir_v_d = ir_v_q;
    if (!stall_i) begin
      ir_v_d = instr_valid_i;
      if (instr_valid_i) ir_d = next_instr_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ir_q   <= '0;
      ir_v_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      ir_v_q <= ir_v_d;
    end
  end

  jmp_tracker #(
    .JMP_ADDR_WORDS(JMP_ADDR_WORDS)
  ) u_jmp_tracker (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .ir_v_i     (ir_v_q),
    .stall_i    (stall_i),
    .is_jmp_i   (ir_q[W-1 -: 3] == OP_JMP),
    .cond_i     (ir_q[W-4]),
    .busy_o     (busy),
    .last_word_o(last_word),
    .cond_o     (cond)
  );

  assign ld_dst        = ir_q[W-2 -: 3];
  assign dst           = ir_q[W-3 -: 3];
  assign src           = ir_q[W-6 -: 3];
  assign instr_ready_o = ~stall_i;
  // The opcode word and non-final address words of a jump do nothing in the datapath.
  assign bubble        = !ir_v_q || stall_i || (busy && !last_word);

  always_comb begin
    reg_en_o     = '0;
    source_sel_o = ZERO_SRC;
    ir_nibble_o  = ir_q[NIBBLE_W-1:0];
    i_sel_o      = 1'b1;
    x_sel_o      = 1'b0;
    y_sel_o      = 1'b0;
    alu_func_o   = 3'd0;
    jmp_o        = 1'b0;
    jmp_nz_o     = 1'b0;
    jmp_busy_o   = busy;
    if (!reset_ni) begin
      reg_en_o    = '1;
      i_sel_o     = 1'b0;
      ir_nibble_o = '0;
      jmp_busy_o  = 1'b0;
    end else if (!bubble) begin
      if (last_word) begin
        jmp_o    = ~cond;
        jmp_nz_o = cond;
      end else if (ir_q[W-1] == OP_LOAD) begin
        reg_en_o     = EnOne << dst_index(ld_dst);
        source_sel_o = IMM_SRC;
        i_sel_o      = ({1'b0, ld_dst} != REG_I);
        // A dm write post-increments the i pointer.
        if ({1'b0, ld_dst} == REG_DM) reg_en_o = reg_en_o | (EnOne << REG_I);
      end else if (ir_q[W-1 -: 2] == OP_MOVE) begin
        reg_en_o = EnOne << dst_index(dst);
        if (dst != src)                     source_sel_o = {1'b0, src};
        else if ({1'b0, dst} == REG_R)      source_sel_o = R_SRC;
        else                                source_sel_o = IPIN_SRC;
        i_sel_o = ({1'b0, dst} != REG_I);
        if (({1'b0, dst} == REG_I) || ({1'b0, dst} == REG_DM) || ({1'b0, src} == REG_DM)) begin
          reg_en_o = reg_en_o | (EnOne << REG_I);
        end
      end else begin
        reg_en_o   = EnOne << REG_R;
        x_sel_o    = ir_q[W-4];
        y_sel_o    = ir_q[W-5];
        alu_func_o = ir_q[W-6 -: 3];
      end
    end
  end

`ifdef INSTR_DECODER_TRACE_EN
  logic [15:0] retired_q, retired_d;

  assign retired_d = bubble ? retired_q : retired_q + 16'd1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) retired_q <= '0;
    else           retired_q <= retired_d;
  end

  assign dbg_ir_o      = ir_q;
  assign dbg_retired_o = retired_q;

  // The i-pointer increment strobe may accompany one destination enable.
  reg_en_onehot_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
    $onehot0(reg_en_o & ~(EnOne << REG_I)));
`endif

endmodule
